// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction prefetch queue with redirect flush and halt
module instr_fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              AW       = 16,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   Instruction,
   output logic [31:0]   Instruction_next,
   output logic          instr_valid,
   output logic          instr_next_valid,
   output logic [AW-1:0] instr_pc,
   output logic          next_is_branch,
   input  logic          id_ready,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_fetch_pc;
   logic [AW-1:0]   r_resp_pc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [31:0]     r_word [DEPTH];
   logic [AW-1:0]   r_pc   [DEPTH];

   logic            w_credit;
   logic            w_accept;
   logic            w_rsp;
   logic            w_push;
   logic            w_pop;
   logic            w_next_valid;
   logic [PW-1:0]   w_rd_next;
   logic [CW:0]     w_inflight;
   logic [6:0]      w_next_op;

   // Credit counts queued words plus words still in flight, so every
   // accepted request is guaranteed a free slot when its data returns.
   assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_credit       = (w_inflight < C_DEPTH);
   assign imem_req_valid = !rst && (r_state == ST_RUN) && !redirect_valid && !halt && w_credit;
   assign imem_addr      = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding (a straggler from before a reset) is ignored.
   assign w_rsp  = imem_rsp_valid && (r_outstanding != '0);
   assign w_push = w_rsp && !redirect_valid && (r_drop == '0);
   assign w_pop  = id_ready && instr_valid && !redirect_valid;

   assign w_rd_next = r_rd_ptr + PW'(1);

   assign instr_valid      = (r_count != '0);
   assign w_next_valid     = (r_count > CW'(1));
   assign instr_next_valid = w_next_valid;
   assign Instruction      = r_word[r_rd_ptr];
   assign instr_pc         = r_pc[r_rd_ptr];
   assign Instruction_next = w_next_valid ? r_word[w_rd_next] : 32'h0;
   assign w_next_op        = Instruction_next[31:25];
   assign next_is_branch   = w_next_valid &&
                             ((w_next_op == 7'b1100000) || (w_next_op == 7'b1100010));

   // PCs, occupancy, in-flight/drop bookkeeping and run/halt state; redirect overrides all
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
         if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            // everything still in flight after this cycle belongs to the old path
            r_drop     <= r_outstanding - CW'(w_rsp);
         end else begin
            if (halt) begin
               r_state <= ST_HALTED;
            end
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + AW'(1);
            end
            if (w_rsp && (r_drop != '0)) begin
               r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + AW'(1);
               r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // Queue storage: a push writes the returned word and its PC into the tail slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_word[i] <= '0;
            r_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_word[r_wr_ptr] <= imem_rdata;
         r_pc[r_wr_ptr]   <= r_resp_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic [31:0] Instruction_next;
   logic        instr_valid;
   logic        instr_next_valid;
   logic [15:0] instr_pc;
   logic        next_is_branch;
   logic        id_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;

   instr_fetch_queue #(.DEPTH(4), .AW(16), .RESET_PC(16'h0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_addr        (imem_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rdata       (imem_rdata),
      .Instruction      (Instruction),
      .Instruction_next (Instruction_next),
      .instr_valid      (instr_valid),
      .instr_next_valid (instr_next_valid),
      .instr_pc         (instr_pc),
      .next_is_branch   (next_is_branch),
      .id_ready         (id_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .halt             (halt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] word; logic [15:0] pc; } ent_t;
   typedef struct { logic [15:0] addr; bit stale; } flight_t;
   typedef struct { logic [15:0] addr; int due; } mreq_t;

   // model: decode-visible queue, fetches in flight (oldest first), next fetch address
   ent_t        mq[$];
   flight_t     mflight[$];
   logic [15:0] m_fetch_pc;
   bit          m_halted;

   // memory environment
   mreq_t       mem_q[$];
   int          lat;
   int          cyc;
   int          acc_count;
   bit          smp_acc;
   logic [15:0] smp_addr;

   int          errors;
   int          checks;
   logic [15:0] last_pc;

   logic [31:0] c_nx;
   logic [6:0]  c_op;
   bit          c_br;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0101: return 32'hC000_0010;
         16'h0102: return 32'hC400_0000;
         16'h0103: return 32'h0000_0000;
         default:  return {16'h5A00, a};
      endcase
   endfunction

   function automatic bit exp_req_valid();
      return !rst && !m_halted && !redirect_valid && !halt &&
             ((mq.size() + mflight.size()) < 4);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mflight.delete();
      m_fetch_pc = 16'h0000;
      m_halted   = 1'b0;
   endtask

   task automatic model_step();
      bit      acc;
      bit      rsp;
      flight_t f;
      ent_t    e;
      acc = exp_req_valid() && imem_req_ready;
      rsp = imem_rsp_valid && (mflight.size() > 0);
      f.addr  = 16'h0;
      f.stale = 1'b1;
      if (rsp) f = mflight.pop_front();
      if (redirect_valid) begin
         mq.delete();
         foreach (mflight[i]) mflight[i].stale = 1'b1;
         m_fetch_pc = redirect_pc;
         m_halted   = 1'b0;
      end else begin
         if (id_ready && mq.size() > 0) mq.delete(0);
         if (rsp && !f.stale) begin
            e.word = mem_word(f.addr);
            e.pc   = f.addr;
            mq.push_back(e);
         end
         if (acc) begin
            f.addr  = m_fetch_pc;
            f.stale = 1'b0;
            mflight.push_back(f);
            m_fetch_pc = m_fetch_pc + 16'd1;
         end
         if (halt) m_halted = 1'b1;
      end
   endtask

   task automatic mem_step();
      mreq_t r;
      if (imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
      if (smp_acc) begin
         r.addr = smp_addr;
         r.due  = cyc + lat;
         mem_q.push_back(r);
         acc_count++;
      end
   endtask

   task automatic mem_drive();
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rdata     = mem_word(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rdata     = 32'h0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      mem_step();
      cyc++;
      #1;
      mem_drive();
   endtask

   // every cycle: compare all DUT outputs with the model, and sample the request handshake
   always @(negedge clk) begin
      smp_acc  = imem_req_valid && imem_req_ready;
      smp_addr = imem_addr;
      c_nx = (mq.size() >= 2) ? mq[1].word : 32'h0;
      c_op = c_nx[31:25];
      c_br = (mq.size() >= 2) && ((c_op == 7'b1100000) || (c_op == 7'b1100010));
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
      chk("req_addr", 32'(imem_addr), 32'(m_fetch_pc));
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() >= 1));
      chk("instr_next_valid", 32'(instr_next_valid), 32'(mq.size() >= 2));
      chk("instruction_next", Instruction_next, c_nx);
      chk("next_is_branch", 32'(next_is_branch), 32'(c_br));
      if (mq.size() > 0) begin
         chk("instruction", Instruction, mq[0].word);
         chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
      end
   end

   initial begin
      errors = 0; checks = 0; cyc = 0; acc_count = 0; lat = 1;
      smp_acc = 1'b0; smp_addr = 16'h0;
      rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
      id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
      model_reset();

      // reset values
      tick(); tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instruction", Instruction, 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);

      // fill with decode stalled: four requests then none
      rst = 1'b0; acc_count = 0;
      repeat (10) tick();
      chk("t1_req_count", 32'(acc_count), 32'd4);
      chk("t1_head_pc", 32'(instr_pc), 32'h0000);
      chk("t1_head_word", Instruction, 32'h5A00_0000);
      chk("t1_next_word", Instruction_next, 32'h5A00_0001);
      chk("t1_addr", 32'(imem_addr), 32'h0004);
      chk("t1_no_5th_req", 32'(imem_req_valid), 32'd0);

      // steady consumption: head PCs strictly sequential, next is the following word
      id_ready = 1'b1; last_pc = 16'hFFFF;
      for (int i = 0; i < 12; i++) begin
         if (instr_valid) begin
            chk("t2_pop_order", 32'(instr_pc), 32'(16'(last_pc + 16'd1)));
            last_pc = instr_pc;
            if (instr_next_valid)
               chk("t2_next_word", Instruction_next, mem_word(16'(instr_pc + 16'd1)));
         end
         tick();
      end

      // redirect with two fetches in flight
      lat = 2;
      for (int i = 0; i < 20 && mflight.size() != 2; i++) tick();
      chk("t3_two_inflight", 32'(mflight.size()), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 16'h0040; id_ready = 1'b0;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      chk("t3_head_pc", 32'(instr_pc), 32'h0040);
      chk("t3_head_word", Instruction, 32'h5A00_0040);
      repeat (8) tick();
      chk("t3_next_word", Instruction_next, 32'h5A00_0041);

      // address wrap
      lat = 1; redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      repeat (8) tick();
      chk("t4_head_pc", 32'(instr_pc), 32'hFFFE);
      chk("t4_next_word", Instruction_next, 32'h5A00_FFFF);
      chk("t4_addr_wrap", 32'(imem_addr), 32'h0002);
      id_ready = 1'b1;
      tick(); tick();
      id_ready = 1'b0;
      chk("t4_pc_wrap", 32'(instr_pc), 32'h0000);
      chk("t4_word_wrap", Instruction, 32'h5A00_0000);

      // halt with two outstanding, then resume through redirect
      lat = 3; redirect_valid = 1'b1; redirect_pc = 16'h0080; id_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20 && mflight.size() != 2; i++) tick();
      chk("t5_two_inflight", 32'(mflight.size()), 32'd2);
      halt = 1'b1; id_ready = 1'b0; acc_count = 0;
      tick();
      halt = 1'b0;
      repeat (8) tick();
      chk("t5_no_req_count", 32'(acc_count), 32'd0);
      chk("t5_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t5_both_enqueued", 32'(instr_next_valid), 32'd1);
      lat = 1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      repeat (8) tick();
      chk("t5_resume_pc", 32'(instr_pc), 32'h0100);

      // branch detection on Instruction_next
      chk("t6_next_c000", Instruction_next, 32'hC000_0010);
      chk("t6_branch_a", 32'(next_is_branch), 32'd1);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      repeat (4) tick();
      chk("t6_next_c400", Instruction_next, 32'hC400_0000);
      chk("t6_branch_b", 32'(next_is_branch), 32'd1);
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      repeat (4) tick();
      chk("t6_next_zero", Instruction_next, 32'h0000_0000);
      chk("t6_branch_c", 32'(next_is_branch), 32'd0);

      // reset mid-burst; late responses must not enqueue
      lat = 3; id_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b1; imem_req_ready = 1'b0; id_ready = 1'b0;
      model_reset();
      #1;
      chk("r_req_valid", 32'(imem_req_valid), 32'd0);
      chk("r_instr_valid", 32'(instr_valid), 32'd0);
      chk("r_next_valid", 32'(instr_next_valid), 32'd0);
      chk("r_instruction", Instruction, 32'd0);
      chk("r_instr_next", Instruction_next, 32'd0);
      chk("r_instr_pc", 32'(instr_pc), 32'd0);
      chk("r_imem_addr", 32'(imem_addr), 32'd0);
      chk("r_branch", 32'(next_is_branch), 32'd0);
      tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("r_late_ignored", 32'(instr_valid), 32'd0);
      imem_req_ready = 1'b1; lat = 1;
      repeat (8) tick();
      chk("r_restart_pc", 32'(instr_pc), 32'h0000);
      chk("r_restart_word", Instruction, 32'h5A00_0000);
      chk("r_restart_next", Instruction_next, 32'h5A00_0001);

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
